// File: rtl/thcattus_uart_rx_pkg.sv
// Shared definitions for the thcattus UART: one-hot line-state encoding and baud divider.
// Kept common so the transmit and receive sides agree on both.

package thcattus_uart_rx_pkg;

    typedef enum logic [4:0] {
        StIdle     = 5'b00001,
        StStart    = 5'b00010,
        StData     = 5'b00100,
        StStop     = 5'b01000,
        StWaitIdle = 5'b10000
    } uart_state_e;

    // Truncating divide; callers must keep the result >= 4.
    function automatic int unsigned clks_per_bit(input int unsigned clk_freq,
                                                 input int unsigned baud_rate);
        return clk_freq / baud_rate;
    endfunction

endpackage

// File: rtl/thcattus_uart_rx_byte.sv
// Byte-level 8N1 receiver: input synchroniser, bit FSM and baud/bit counters.
// Emits a one-cycle byte_valid or byte_ferr at the mid-stop-bit sample.

module thcattus_uart_rx_byte
    import thcattus_uart_rx_pkg::*;
#(
    parameter int unsigned ClksPerBit = 10
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       rx_i,
    output logic       byte_valid_o,
    output logic [7:0] byte_data_o,
    output logic       byte_ferr_o,
    output logic       idle_o
);

    localparam int unsigned CntW = $clog2(ClksPerBit);
    localparam logic [CntW-1:0] HalfLast = CntW'(ClksPerBit / 2 - 1);
    localparam logic [CntW-1:0] FullLast = CntW'(ClksPerBit - 1);

    uart_state_e     state_q, state_d;
    logic            rx_meta_q, rxs_q;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= StIdle;
            rx_meta_q <= 1'b1;
            rxs_q     <= 1'b1;
            cnt_q     <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
        end else begin
            state_q   <= state_d;
            rx_meta_q <= rx_i;
            rxs_q     <= rx_meta_q;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q + 1'b1;
        bit_d        = bit_q;
        shift_d      = shift_q;
        byte_valid_o = 1'b0;
        byte_ferr_o  = 1'b0;
        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (!rxs_q) state_d = StStart;
            end
            StStart: begin
                // Half a bit in: a start bit that has already gone high was a glitch.
                if (cnt_q == HalfLast) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = rxs_q ? StIdle : StData;
                end
            end
            StData: begin
                if (cnt_q == FullLast) begin
                    cnt_d   = '0;
                    shift_d = {rxs_q, shift_q[7:1]};
                    bit_d   = bit_q + 1'b1;
                    if (bit_q == 3'd7) state_d = StStop;
                end
            end
            StStop: begin
                if (cnt_q == FullLast) begin
                    cnt_d = '0;
                    if (rxs_q) begin
                        byte_valid_o = 1'b1;
                        state_d      = StIdle;
                    end else begin
                        byte_ferr_o = 1'b1;
                        state_d     = StWaitIdle;
                    end
                end
            end
            StWaitIdle: begin
                cnt_d = '0;
                if (rxs_q) state_d = StIdle;
            end
            default: begin
                cnt_d   = '0;
                state_d = StIdle;
            end
        endcase
    end

    assign byte_data_o = shift_q;
    assign idle_o      = (state_q == StIdle);

endmodule

// File: rtl/thcattus_uart_rx.sv
// UART receiver top: assembles DATA_BYTES bytes into one word and presents it on an
// AXI-Stream-style master port, with partial-word timeout and error/overrun pulses.

module thcattus_uart_rx
    import thcattus_uart_rx_pkg::*;
#(
    parameter int unsigned CLK_FREQ     = 50_000_000,
    parameter int unsigned BAUD_RATE    = 115_200,
    parameter int unsigned DATA_BYTES   = 12,
    parameter int unsigned TIMEOUT_BITS = 20
) (
    input  logic                    axis_aclk,
    input  logic                    axis_arestn,
    input  logic                    uart_rx,
    output logic                    axis_tvalid,
    input  logic                    axis_tready,
    output logic [8*DATA_BYTES-1:0] axis_tdata,
    output logic                    frame_error,
    output logic                    overrun
);

    localparam int unsigned ClksPerBit  = clks_per_bit(CLK_FREQ, BAUD_RATE);
    localparam int unsigned IdxW        = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1;
    localparam int unsigned TimeoutClks = TIMEOUT_BITS * ClksPerBit;
    localparam int unsigned ToW         = (TimeoutClks > 1) ? $clog2(TimeoutClks) : 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(DATA_BYTES - 1);
    localparam logic [ToW-1:0]  ToLast  = ToW'((TimeoutClks > 0) ? TimeoutClks - 1 : 0);

    logic                    byte_valid, byte_ferr, rx_idle;
    logic [7:0]              byte_data;
    logic [8*DATA_BYTES-1:0] word_q, word_d;
    logic [8*DATA_BYTES-1:0] tdata_q, tdata_d;
    logic [IdxW-1:0]         idx_q, idx_d;
    logic [ToW-1:0]          to_cnt_q, to_cnt_d;
    logic                    done_q, done_d;
    logic                    tvalid_q, tvalid_d;
    logic                    ferr_q, ovr_q, ovr_d;

    thcattus_uart_rx_byte #(
        .ClksPerBit(ClksPerBit)
    ) u_byte (
        .clk_i       (axis_aclk),
        .rst_ni      (axis_arestn),
        .rx_i        (uart_rx),
        .byte_valid_o(byte_valid),
        .byte_data_o (byte_data),
        .byte_ferr_o (byte_ferr),
        .idle_o      (rx_idle)
    );

    always_ff @(posedge axis_aclk or negedge axis_arestn) begin
        if (!axis_arestn) begin
            word_q   <= '0;
            tdata_q  <= '0;
            idx_q    <= '0;
            to_cnt_q <= '0;
            done_q   <= 1'b0;
            tvalid_q <= 1'b0;
            ferr_q   <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            word_q   <= word_d;
            tdata_q  <= tdata_d;
            idx_q    <= idx_d;
            to_cnt_q <= to_cnt_d;
            done_q   <= done_d;
            tvalid_q <= tvalid_d;
            ferr_q   <= byte_ferr;
            ovr_q    <= ovr_d;
        end
    end

    // Word assembly and partial-word timeout.
    always_comb begin
        word_d   = word_q;
        idx_d    = idx_q;
        done_d   = 1'b0;
        to_cnt_d = '0;
        if (byte_valid) begin
            word_d[{idx_q, 3'b000} +: 8] = byte_data;
            if (idx_q == LastIdx) begin
                idx_d  = '0;
                done_d = 1'b1;
            end else begin
                idx_d = idx_q + 1'b1;
            end
        end else if (byte_ferr) begin
            idx_d = '0;
        end else if (TIMEOUT_BITS != 0 && rx_idle && idx_q != '0) begin
            if (to_cnt_q == ToLast) idx_d = '0;
            else                    to_cnt_d = to_cnt_q + 1'b1;
        end
    end

    // Output register: a completed word loads only if the slot is free or draining now.
    always_comb begin
        tvalid_d = tvalid_q & ~axis_tready;
        tdata_d  = tdata_q;
        ovr_d    = 1'b0;
        if (done_q) begin
            if (!tvalid_q || axis_tready) begin
                tdata_d  = word_q;
                tvalid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end
    end

    assign axis_tvalid = tvalid_q;
    assign axis_tdata  = tdata_q;
    assign frame_error = ferr_q;
    assign overrun     = ovr_q;

endmodule

// File: tb/tb_thcattus_uart_rx.sv
// Directed bench for thcattus_uart_rx: a byte/word-level model predicts beats and
// error/overrun pulses; a per-cycle monitor compares the DUT against it.

module tb_thcattus_uart_rx;

    localparam int unsigned Cpb = 10;

    logic        clk = 1'b0;
    logic        arestn;
    logic        rx;
    logic        tready;
    logic        tvalid;
    logic [95:0] tdata;
    logic        ferr, ovr;

    int n_checks = 0;
    int n_err    = 0;

    // Model state
    logic [7:0]  m_bytes[$];
    logic [95:0] exp_q[$];
    int          exp_ferr = 0, exp_ovr = 0;
    // Monitor observations
    int          mon_ferr = 0, mon_ovr = 0, mon_beats = 0;
    logic [95:0] last_beat = '0;

    always #5 clk = ~clk;

    thcattus_uart_rx #(
        .CLK_FREQ    (1_000_000),
        .BAUD_RATE   (100_000),
        .DATA_BYTES  (12),
        .TIMEOUT_BITS(20)
    ) dut (
        .axis_aclk  (clk),
        .axis_arestn(arestn),
        .uart_rx    (rx),
        .axis_tvalid(tvalid),
        .axis_tready(tready),
        .axis_tdata (tdata),
        .frame_error(ferr),
        .overrun    (ovr)
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Model: a byte takes effect when its stop bit is put on the line.
    task automatic model_byte(input logic [7:0] b, input logic stop);
        logic [95:0] w;
        if (!stop) begin
            m_bytes.delete();
            exp_ferr++;
        end else begin
            m_bytes.push_back(b);
            if (m_bytes.size() == 12) begin
                for (int i = 0; i < 12; i++) w[i*8 +: 8] = m_bytes[i];
                m_bytes.delete();
                if (exp_q.size() != 0) exp_ovr++;
                else                   exp_q.push_back(w);
            end
        end
    endtask

    // Idle gaps of 200+ clocks discard a partial word.
    task automatic idle_gap(input int n);
        rx = 1'b1;
        wait_clks(n);
        if (n >= 20 * Cpb) m_bytes.delete();
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        rx = 1'b0;
        wait_clks(Cpb);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            wait_clks(Cpb);
        end
        rx = stop;
        model_byte(b, stop);
        wait_clks(Cpb);
        if (!stop) begin
            rx = 1'b1;
            wait_clks(2 * Cpb);
        end
    endtask

    task automatic send_word(input logic [7:0] first);
        for (int i = 0; i < 12; i++) send_byte(first + 8'(i), 1'b1);
    endtask

    task automatic drain_and_check(input string name);
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) wait_clks(1);
        chk({name, "_drain"}, 128'(exp_q.size()), 128'd0);
        chk({name, "_ferr_cnt"}, 128'(mon_ferr), 128'(exp_ferr));
        chk({name, "_ovr_cnt"}, 128'(mon_ovr), 128'(exp_ovr));
    endtask

    // Per-cycle compare against the model.
    always @(negedge clk) begin
        if (arestn) begin
            if (ferr) mon_ferr++;
            if (ovr)  mon_ovr++;
            chk("ferr_ovr_exclusive", 128'(ferr & ovr), 128'd0);
            if (exp_q.size() == 0) begin
                chk("tvalid_unexpected", 128'(tvalid), 128'd0);
            end else if (tvalid) begin
                chk("tdata", 128'(tdata), 128'(exp_q[0]));
                if (tready) begin
                    last_beat = tdata;
                    mon_beats++;
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        int beats0;
        arestn = 1'b0;
        rx     = 1'b1;
        tready = 1'b1;
        wait_clks(3);
        chk("rst_tvalid", 128'(tvalid), 128'd0);
        chk("rst_tdata", 128'(tdata), 128'd0);
        chk("rst_ferr", 128'(ferr), 128'd0);
        chk("rst_ovr", 128'(ovr), 128'd0);
        arestn = 1'b1;
        wait_clks(20);

        // 1: one clean word, back to back
        beats0 = mon_beats;
        send_word(8'h01);
        drain_and_check("t1");
        chk("t1_beats", 128'(mon_beats - beats0), 128'd1);
        chk("t1_literal", 128'(last_beat), 128'(96'h0C0B0A09_08070605_04030201));

        // 2: short low glitch, then a good word
        rx = 1'b0;
        wait_clks(3);
        rx = 1'b1;
        wait_clks(40);
        chk("t2_glitch_ferr", 128'(mon_ferr), 128'd0);
        beats0 = mon_beats;
        send_word(8'h51);
        drain_and_check("t2");
        chk("t2_beats", 128'(mon_beats - beats0), 128'd1);
        chk("t2_literal", 128'(last_beat), 128'(96'h5C5B5A59_58575655_54535251));

        // 3: bad stop bit, then a full word
        beats0 = mon_beats;
        send_byte(8'h05, 1'b0);
        chk("t3_ferr_pulse", 128'(mon_ferr), 128'd1);
        send_word(8'hA0);
        drain_and_check("t3");
        chk("t3_beats", 128'(mon_beats - beats0), 128'd1);
        chk("t3_literal", 128'(last_beat), 128'(96'hABAAA9A8_A7A6A5A4_A3A2A1A0));

        // 4: backpressure with a second word -> overrun, W1 only
        tready = 1'b0;
        beats0 = mon_beats;
        send_word(8'h20);
        chk("t4_tvalid_held", 128'(tvalid), 128'd1);
        send_word(8'h30);
        wait_clks(5);
        chk("t4_ovr_pulse", 128'(mon_ovr), 128'd1);
        chk("t4_tdata_w1", 128'(tdata), 128'(96'h2B2A2928_27262524_23222120));
        tready = 1'b1;
        drain_and_check("t4");
        chk("t4_beats", 128'(mon_beats - beats0), 128'd1);
        chk("t4_literal", 128'(last_beat), 128'(96'h2B2A2928_27262524_23222120));

        // 5: partial word timed out by idle gap
        beats0 = mon_beats;
        for (int i = 0; i < 5; i++) send_byte(8'hE0 + 8'(i), 1'b1);
        idle_gap(250);
        send_word(8'h10);
        drain_and_check("t5");
        chk("t5_beats", 128'(mon_beats - beats0), 128'd1);
        chk("t5_literal", 128'(last_beat), 128'(96'h1B1A1918_17161514_13121110));

        // 6: reset mid byte 3 with a word held on the output
        tready = 1'b0;
        send_word(8'h40);
        send_byte(8'h71, 1'b1);
        send_byte(8'h72, 1'b1);
        rx = 1'b0;
        wait_clks(Cpb);
        for (int i = 0; i < 4; i++) begin
            rx = i[0];
            wait_clks(Cpb);
        end
        arestn = 1'b0;
        #1;
        exp_q.delete();
        m_bytes.delete();
        chk("t6_rst_tvalid", 128'(tvalid), 128'd0);
        chk("t6_rst_tdata", 128'(tdata), 128'd0);
        chk("t6_rst_ferr", 128'(ferr), 128'd0);
        chk("t6_rst_ovr", 128'(ovr), 128'd0);
        rx = 1'b1;
        wait_clks(5);
        arestn = 1'b1;
        tready = 1'b1;
        wait_clks(20);
        beats0 = mon_beats;
        send_word(8'h60);
        drain_and_check("t6");
        chk("t6_beats", 128'(mon_beats - beats0), 128'd1);
        chk("t6_literal", 128'(last_beat), 128'(96'h6B6A6968_67666564_63626160));

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
